// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath encodings for the write-back stage
package cpu_pkg;

  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_HALF = 2'b01,
    LD_BYTE = 2'b10,
    LD_RSVD = 2'b11
  } ld_size_e;

  // MemToReg selector codes
  localparam int SRC_ALU   = 0;
  localparam int SRC_MEM   = 1;
  localparam int SRC_PC4   = 2;
  localparam int SRC_CONST = 3;

  localparam int REG_ZERO  = 0;

endpackage

// File: rtl/wb_data_unit_if.sv
// rtl/wb_data_unit_if.sv - write-back request and register-file write port bundle
interface wb_data_unit_if #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 8,
  parameter int SEL_W  = $clog2(N_SRC),
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);

  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [1:0]              ld_size;
  logic                    ld_signed;
  logic [1:0]              byte_off;
  logic [ADDR_W-1:0]       wr_addr_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [CNT_W-1:0]        wr_count;
  logic                    sel_err;

  modport master (
    output in_valid, sel, src_data, ld_size, ld_signed, byte_off, wr_addr_in, out_ready,
    input  in_ready, out_valid, wr_addr, wr_data, wr_count, sel_err
  );

  modport slave (
    input  in_valid, sel, src_data, ld_size, ld_signed, byte_off, wr_addr_in, out_ready,
    output in_ready, out_valid, wr_addr, wr_data, wr_count, sel_err
  );

endinterface

// File: rtl/wb_data_unit_load_extend.sv
// rtl/wb_data_unit_load_extend.sv - little-endian byte/half lane select with sign/zero extension
module load_extend
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [1:0]        byte_off,
  output logic [DATA_W-1:0] ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{byte_off, 3'b000} +: 8];
    half_lane = rdata[{byte_off[1], 4'b0000} +: 16];
    case (ld_size)
      LD_BYTE: ext = {{(DATA_W-8){ld_signed & byte_lane[7]}}, byte_lane};
      LD_HALF: ext = {{(DATA_W-16){ld_signed & half_lane[15]}}, half_lane};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/wb_data_unit.sv
// rtl/wb_data_unit.sv - registered write-back source mux with one-entry output stage
module wb_data_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int N_SRC     = 8,
  parameter int SEL_W     = $clog2(N_SRC),
  parameter int CONST_IDX = SRC_CONST,
  parameter int CONST_VAL = 227,
  parameter int LOAD_IDX  = SRC_MEM,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  wb_data_unit_if.slave bus
);

  logic [DATA_W-1:0] slot [N_SRC];
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] result;
  logic              illegal;
  logic              accept;
  logic              drain;
  logic              keep;

  logic              out_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [CNT_W-1:0]  wr_count_q;
  logic              sel_err_q;

  for (genvar k = 0; k < N_SRC; k++) begin : g_slot
    assign slot[k] = bus.src_data[k*DATA_W +: DATA_W];
  end

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .rdata     (slot[LOAD_IDX]),
    .ld_size   (bus.ld_size),
    .ld_signed (bus.ld_signed),
    .byte_off  (bus.byte_off),
    .ext       (load_data)
  );

  // Codes above N_SRC-1 only exist when N_SRC is not a power of two
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    if (bus.sel == SEL_W'(CONST_IDX)) begin
      result = DATA_W'(CONST_VAL);
    end else if (bus.sel == SEL_W'(LOAD_IDX)) begin
      result = load_data;
    end else if (int'(bus.sel) < N_SRC) begin
      result = slot[bus.sel];
    end else begin
      illegal = 1'b1;
    end
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = out_valid_q && bus.out_ready;
  assign keep         = bus.wr_addr_in != ADDR_W'(REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_count_q  <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      if (drain) begin
        wr_count_q <= wr_count_q + CNT_W'(1);
      end
      if (accept && illegal) begin
        sel_err_q <= 1'b1;
      end
      if (accept && keep) begin
        out_valid_q <= 1'b1;
        wr_addr_q   <= bus.wr_addr_in;
        wr_data_q   <= result;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_count  = wr_count_q;
  assign bus.sel_err   = sel_err_q;

endmodule
